dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between four requesters: 0 = general-purpose register X/Y path, 1 = accumulator STA/LDA path, 2 = stack PUSH/POP of PC, 3 = crypto core result/operand path.
- Replaces the per-source write enables on the data memory with one arbitrated port and a req/gnt/ack handshake.
- Round-robin arbitration, with an optional fixed-priority override for the stack port.
- Sits between the control unit/datapath requesters and data_mem.

---
 rtl/dmem_port_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Shares the single data-memory port between N_REQ requesters
//               (0 = GPR X/Y, 1 = accumulator STA/LDA, 2 = stack PUSH/POP,
//               3 = crypto core) using a req/gnt/ack handshake. Round-robin
//               arbitration with an optional fixed-priority override.
// Ports       : clk, rst (async, active-low)
//               req/we/addr/wdata   - requester side (flattened per index)
//               gnt/ack/rdata       - requester responses
//               mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - memory side
//               busy                - arbiter not idle
//               proto_err           - granted requester dropped req early
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int N_REQ    = 4,
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int PRIO_EN  = 1,
    parameter int PRIO_IDX = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic [DW-1:0]       rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    output logic                busy,
    output logic                proto_err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(RD_LAT + 1);

    localparam logic [IW-1:0] c_last_init = IW'(N_REQ - 1);
    localparam logic [IW-1:0] c_prio_idx  = IW'(PRIO_IDX);
    localparam logic [CW-1:0] c_rd_lat    = CW'(RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [IW-1:0]   r_win;       // index of the requester being served
    logic [IW-1:0]   r_last;      // round-robin pointer: last winner
    logic [CW-1:0]   r_cnt;       // read latency counter
    logic            r_drop;      // winner dropped req before completion

    logic [IW-1:0]   w_win_nxt;
    logic [IW-1:0]   w_last_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_drop_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [N_REQ-1:0] w_ack_nxt;
    logic [DW-1:0]   w_rdata_nxt;
    logic            w_mem_en_nxt;
    logic            w_mem_we_nxt;
    logic [AW-1:0]   w_mem_addr_nxt;
    logic [DW-1:0]   w_mem_wdata_nxt;
    logic            w_busy_nxt;
    logic            w_perr_nxt;

    // ------------------------------------------------------------------
    // Winner selection (only used in IDLE)
    // ------------------------------------------------------------------
    logic [IW-1:0]    w_rr_win;
    logic [IW-1:0]    w_scan_idx;
    logic             w_found;
    logic [IW-1:0]    w_sel;
    logic [N_REQ-1:0] w_sel_oh;
    logic [N_REQ-1:0] w_win_oh;

    always_comb begin
        w_rr_win   = r_last;
        w_found    = 1'b0;
        w_scan_idx = '0;
        // Scan last+1, last+2, ... wrapping, so the last winner is checked last.
        for (int i = 1; i <= N_REQ; i++) begin
            w_scan_idx = IW'((int'(r_last) + i) % N_REQ);
            if (!w_found && req[w_scan_idx]) begin
                w_rr_win = w_scan_idx;
                w_found  = 1'b1;
            end
        end
        if ((PRIO_EN != 0) && req[c_prio_idx]) begin
            w_sel = c_prio_idx;
        end else begin
            w_sel = w_rr_win;
        end
        w_sel_oh        = '0;
        w_sel_oh[w_sel] = 1'b1;
        w_win_oh        = '0;
        w_win_oh[r_win] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Every output is the registered
    // version of a *_nxt value, so outputs change only on clock edges.
    // mem_we/mem_addr/mem_wdata double as the latched request fields and
    // hold their value until the next grant.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_win_nxt       = r_win;
        w_last_nxt      = r_last;
        w_cnt_nxt       = r_cnt;
        w_drop_nxt      = r_drop;
        w_gnt_nxt       = gnt;
        w_ack_nxt       = '0;
        w_rdata_nxt     = rdata;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = mem_we;
        w_mem_addr_nxt  = mem_addr;
        w_mem_wdata_nxt = mem_wdata;
        w_perr_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt     = S_ISSUE;
                    w_win_nxt       = w_sel;
                    w_last_nxt      = w_sel;
                    w_cnt_nxt       = CW'(1);
                    w_drop_nxt      = 1'b0;
                    w_gnt_nxt       = w_sel_oh;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = we[w_sel];
                    w_mem_addr_nxt  = addr[int'(w_sel)*AW +: AW];
                    w_mem_wdata_nxt = wdata[int'(w_sel)*DW +: DW];
                end
            end

            S_ISSUE: begin
                w_drop_nxt = r_drop | ~req[r_win];
                if (mem_we) begin
                    w_state_nxt = S_ACK;
                    if (w_drop_nxt) begin
                        w_perr_nxt = 1'b1;
                    end else begin
                        w_ack_nxt = w_win_oh;
                    end
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                w_drop_nxt = r_drop | ~req[r_win];
                // The counter is 1 in the first WAIT cycle, so this edge is
                // RD_LAT cycles after the strobe: mem_rdata is valid now.
                if (r_cnt == c_rd_lat) begin
                    w_state_nxt = S_ACK;
                    if (w_drop_nxt) begin
                        w_perr_nxt = 1'b1;
                    end else begin
                        w_ack_nxt   = w_win_oh;
                        w_rdata_nxt = mem_rdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            S_ACK: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_drop_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_win     <= '0;
            r_last    <= c_last_init;
            r_cnt     <= '0;
            r_drop    <= 1'b0;
            gnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_win     <= w_win_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_drop    <= w_drop_nxt;
            gnt       <= w_gnt_nxt;
            ack       <= w_ack_nxt;
            rdata     <= w_rdata_nxt;
            mem_en    <= w_mem_en_nxt;
            mem_we    <= w_mem_we_nxt;
            mem_addr  <= w_mem_addr_nxt;
            mem_wdata <= w_mem_wdata_nxt;
            busy      <= w_busy_nxt;
            proto_err <= w_perr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Directed self-checking bench for dmem_port_arbiter. Two
//               instances share the requester inputs: u_rr (PRIO_EN=0) and
//               u_pr (PRIO_EN=1), both with RD_LAT=2, each with its own
//               small latency-accurate memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  req;
    logic [3:0]  we;
    logic [8:0]  a [4];
    logic [15:0] d [4];
    logic [35:0] addr;
    logic [63:0] wdata;
    assign addr  = {a[3], a[2], a[1], a[0]};
    assign wdata = {d[3], d[2], d[1], d[0]};

    logic [3:0]  rr_gnt, rr_ack, pr_gnt, pr_ack;
    logic [15:0] rr_rdata, rr_mem_wdata, rr_mem_rdata;
    logic [15:0] pr_rdata, pr_mem_wdata, pr_mem_rdata;
    logic [8:0]  rr_mem_addr, pr_mem_addr;
    logic        rr_mem_en, rr_mem_we, rr_busy, rr_perr;
    logic        pr_mem_en, pr_mem_we, pr_busy, pr_perr;

    dmem_port_arbiter #(.N_REQ(4), .AW(9), .DW(16), .RD_LAT(2), .PRIO_EN(0), .PRIO_IDX(2)) u_rr (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(rr_gnt), .ack(rr_ack), .rdata(rr_rdata), .mem_en(rr_mem_en),
        .mem_we(rr_mem_we), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
        .mem_rdata(rr_mem_rdata), .busy(rr_busy), .proto_err(rr_perr)
    );

    dmem_port_arbiter #(.N_REQ(4), .AW(9), .DW(16), .RD_LAT(2), .PRIO_EN(1), .PRIO_IDX(2)) u_pr (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(pr_gnt), .ack(pr_ack), .rdata(pr_rdata), .mem_en(pr_mem_en),
        .mem_we(pr_mem_we), .mem_addr(pr_mem_addr), .mem_wdata(pr_mem_wdata),
        .mem_rdata(pr_mem_rdata), .busy(pr_busy), .proto_err(pr_perr)
    );

    // Memory contents: 0x055 holds 0x1234, everything else a pattern of the address.
    function automatic logic [15:0] memval(input logic [8:0] ad);
        return (ad == 9'h055) ? 16'h1234 : {7'h2A, ad};
    endfunction

    // Read data is valid only exactly two cycles after the strobe cycle.
    logic        rr_v1 = 1'b0, rr_v2 = 1'b0, pr_v1 = 1'b0, pr_v2 = 1'b0;
    logic [15:0] rr_d1, rr_d2, pr_d1, pr_d2;
    int          rr_en_cnt = 0;
    always @(posedge clk) begin
        rr_v1 <= rr_mem_en & ~rr_mem_we;  rr_d1 <= memval(rr_mem_addr);
        rr_v2 <= rr_v1;                   rr_d2 <= rr_d1;
        pr_v1 <= pr_mem_en & ~pr_mem_we;  pr_d1 <= memval(pr_mem_addr);
        pr_v2 <= pr_v1;                   pr_d2 <= pr_d1;
        if (rr_mem_en) rr_en_cnt <= rr_en_cnt + 1;
    end
    assign rr_mem_rdata = rr_v2 ? rr_d2 : 16'hDEAD;
    assign pr_mem_rdata = pr_v2 ? pr_d2 : 16'hDEAD;

    // Observed instance select: 0 = u_rr, 1 = u_pr
    logic        sel_pr = 1'b0;
    logic [3:0]  o_gnt, o_ack;
    logic        o_mem_en;
    assign o_gnt    = sel_pr ? pr_gnt    : rr_gnt;
    assign o_ack    = sel_pr ? pr_ack    : rr_ack;
    assign o_mem_en = sel_pr ? pr_mem_en : rr_mem_en;

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_strobe(input string tag);
        for (int k = 0; k < 12; k++) begin
            if (o_mem_en === 1'b1) break;
            tick();
        end
        chk(tag, {31'd0, o_mem_en}, 32'd1);
    endtask

    int exp_rr [6] = '{0, 1, 3, 0, 1, 3};
    int en0;

    initial begin
        req = '0;
        we  = '0;
        for (int i = 0; i < 4; i++) begin
            a[i] = 9'(i * 3);
            d[i] = 16'(16'h1100 * (i + 1));
        end
        rst = 1'b0;
        tick();
        tick();

        // ---------------- reset state ----------------
        chk("rst_gnt",   {28'd0, rr_gnt}, 32'd0);
        chk("rst_ack",   {28'd0, rr_ack}, 32'd0);
        chk("rst_busy",  {31'd0, rr_busy}, 32'd0);
        chk("rst_men",   {31'd0, rr_mem_en}, 32'd0);
        chk("rst_rdata", {16'd0, rr_rdata}, 32'd0);
        chk("rst_perr",  {31'd0, pr_perr}, 32'd0);
        rst = 1'b1;

        // ---------------- single write (u_rr) ----------------
        req[1] = 1'b1; we[1] = 1'b1; a[1] = 9'h010; d[1] = 16'hBEEF;
        tick();
        chk("wr_men",   {31'd0, rr_mem_en}, 32'd1);
        chk("wr_mwe",   {31'd0, rr_mem_we}, 32'd1);
        chk("wr_maddr", {23'd0, rr_mem_addr}, 32'h010);
        chk("wr_mwd",   {16'd0, rr_mem_wdata}, 32'hBEEF);
        chk("wr_gnt",   {28'd0, rr_gnt}, 32'h2);
        chk("wr_busy1", {31'd0, rr_busy}, 32'd1);
        chk("wr_ack0",  {28'd0, rr_ack}, 32'd0);
        tick();
        chk("wr_ack",   {28'd0, rr_ack}, 32'h2);
        chk("wr_gnt2",  {28'd0, rr_gnt}, 32'h2);
        chk("wr_busy2", {31'd0, rr_busy}, 32'd1);
        chk("wr_men2",  {31'd0, rr_mem_en}, 32'd0);
        req = '0;
        tick();
        chk("wr_busy3", {31'd0, rr_busy}, 32'd0);
        chk("wr_ack3",  {28'd0, rr_ack}, 32'd0);

        // ---------------- single read, RD_LAT=2 (u_rr) ----------------
        we = '0; a[3] = 9'h055; req[3] = 1'b1;
        tick();
        chk("rd_men",   {31'd0, rr_mem_en}, 32'd1);
        chk("rd_mwe",   {31'd0, rr_mem_we}, 32'd0);
        chk("rd_maddr", {23'd0, rr_mem_addr}, 32'h055);
        chk("rd_gnt",   {28'd0, rr_gnt}, 32'h8);
        tick();
        chk("rd_men1",  {31'd0, rr_mem_en}, 32'd0);
        chk("rd_ack1",  {28'd0, rr_ack}, 32'd0);
        tick();
        chk("rd_men2",  {31'd0, rr_mem_en}, 32'd0);
        chk("rd_ack2",  {28'd0, rr_ack}, 32'd0);
        tick();
        chk("rd_ack",   {28'd0, rr_ack}, 32'h8);
        chk("rd_data",  {16'd0, rr_rdata}, 32'h1234);
        req = '0;
        tick();

        // ---------------- protocol error (u_rr) ----------------
        en0 = rr_en_cnt;
        a[0] = 9'h0AA; req[0] = 1'b1;
        tick();
        chk("pe_men",   {31'd0, rr_mem_en}, 32'd1);
        chk("pe_gnt",   {28'd0, rr_gnt}, 32'h1);
        req[0] = 1'b0;
        tick();
        chk("pe_perr1", {31'd0, rr_perr}, 32'd0);
        chk("pe_ack1",  {28'd0, rr_ack}, 32'd0);
        tick();
        chk("pe_perr2", {31'd0, rr_perr}, 32'd0);
        tick();
        chk("pe_perr",  {31'd0, rr_perr}, 32'd1);
        chk("pe_ack",   {28'd0, rr_ack}, 32'd0);
        chk("pe_rdata", {16'd0, rr_rdata}, 32'h1234);
        tick();
        chk("pe_perr4", {31'd0, rr_perr}, 32'd0);
        chk("pe_busy4", {31'd0, rr_busy}, 32'd0);
        chk("pe_strobes", 32'(rr_en_cnt - en0), 32'd1);

        // ---------------- reset mid-access (u_rr) ----------------
        we = '0; req = 4'b1100;
        tick();
        chk("ra_gnt0",  {28'd0, rr_gnt}, 32'h4);
        tick();
        rst = 1'b0;
        #1;
        chk("ra_gnt",   {28'd0, rr_gnt}, 32'd0);
        chk("ra_busy",  {31'd0, rr_busy}, 32'd0);
        chk("ra_men",   {31'd0, rr_mem_en}, 32'd0);
        chk("ra_rdata", {16'd0, rr_rdata}, 32'd0);
        chk("ra_ack",   {28'd0, rr_ack}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("ra_regnt", {28'd0, rr_gnt}, 32'h4);
        chk("ra_remen", {31'd0, rr_mem_en}, 32'd1);
        req = '0;

        // ---------------- round-robin (u_rr) ----------------
        sel_pr = 1'b0;
        do_reset();
        we = 4'b1111; req = 4'b1011;
        for (int n = 0; n < 6; n++) begin
            wait_strobe("rr_strobe");
            chk("rr_gnt", {28'd0, o_gnt}, 32'(1 << exp_rr[n]));
            tick();
            chk("rr_ack", {28'd0, o_ack}, 32'(1 << exp_rr[n]));
        end
        req = '0;

        // ---------------- priority override (u_pr) ----------------
        sel_pr = 1'b1;
        do_reset();
        we = 4'b1111; req = 4'b0101;
        wait_strobe("pr_strobe1");
        chk("pr_gnt1", {28'd0, o_gnt}, 32'h4);
        tick();
        chk("pr_ack1", {28'd0, o_ack}, 32'h4);
        wait_strobe("pr_strobe2");
        chk("pr_gnt2", {28'd0, o_gnt}, 32'h4);
        tick();
        chk("pr_ack2", {28'd0, o_ack}, 32'h4);
        req[2] = 1'b0;
        wait_strobe("pr_strobe3");
        chk("pr_gnt3", {28'd0, o_gnt}, 32'h1);
        tick();
        chk("pr_ack3", {28'd0, o_ack}, 32'h1);
        req = '0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
`default_nettype wire
